// File: rtl/cpu_trap_pkg.sv
// Shared definitions for the S-mode trap unit: FSM encoding, cause/exception codes,
// the latched trap record and the stvec target computation.
package cpu_trap_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRAP  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef enum logic [4:0] {
        IRQ_SSI = 5'd1,
        IRQ_STI = 5'd5,
        IRQ_SEI = 5'd9
    } irq_code_e;

    typedef enum logic [4:0] {
        EXC_FETCH_MISALIGN = 5'd0,
        EXC_ILLEGAL        = 5'd2,
        EXC_BREAKPOINT     = 5'd3,
        EXC_ECALL          = 5'd8
    } exc_code_e;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] value;
    } trap_rec_t;

    function automatic logic [31:0] irq_cause(input irq_code_e code);
        return {1'b1, 26'b0, code};
    endfunction

    // Vectored mode (stvec[1:0]==1) only offsets interrupts; modes 2/3 behave as direct.
    function automatic logic [31:0] trap_target(input logic [31:0] stvec, input logic [31:0] cause);
        logic [31:0] target;
        target = {stvec[31:2], 2'b00};
        if (stvec[1:0] == 2'b01 && cause[31])
            target = target + {cause[29:0], 2'b00};
        return target;
    endfunction

endpackage

// File: rtl/cpu_trap_if.sv
// Signal bundle between the pipeline/CSR file (master) and the trap unit (slave).
interface cpu_trap_if;
    import cpu_trap_pkg::*;

    logic        inst_done;
    logic [31:0] inst_pc;
    logic [31:0] next_pc;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_value;
    logic        sret;
    logic        irq_ext;
    logic        irq_soft;
    logic        irq_timer;
    logic        status_sie;
    logic [31:0] sie_mask;
    logic [31:0] handler_addr;
    logic [31:0] continue_addr;
    logic        flush_done;

    logic        interrupt;
    logic [31:0] interrupt_cause;
    logic [31:0] interrupt_pc;
    logic [31:0] interrupt_value;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] pending;
    logic [1:0]  fsm_state;

    // Handshake: interrupt and redirect are single-cycle strobes with no back-pressure and their
    // payloads are valid only while the strobe is high; flush_done is the only acknowledge and
    // releases stall, which stays high from the trap/sret boundary until flush_done is sampled.
    modport master (
        output inst_done, inst_pc, next_pc, exc_valid, exc_code, exc_value, sret,
               irq_ext, irq_soft, irq_timer, status_sie, sie_mask, handler_addr,
               continue_addr, flush_done,
        input  interrupt, interrupt_cause, interrupt_pc, interrupt_value, redirect,
               redirect_pc, stall, pending, fsm_state
    );

    modport slave (
        input  inst_done, inst_pc, next_pc, exc_valid, exc_code, exc_value, sret,
               irq_ext, irq_soft, irq_timer, status_sie, sie_mask, handler_addr,
               continue_addr, flush_done,
        output interrupt, interrupt_cause, interrupt_pc, interrupt_value, redirect,
               redirect_pc, stall, pending, fsm_state
    );

endinterface

// File: rtl/cpu_irq_sync.sv
// Multi-flop synchroniser for one asynchronous level-sensitive interrupt line.
module cpu_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ff_q <= '0;
        else
            ff_q <= {ff_q[STAGES-2:0], d};
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/cpu_trap_unit.sv
// S-mode trap controller: prioritises exceptions, sret and interrupts at instruction boundaries,
// strobes the CSR file for trap entry and redirects fetch, stalling until the flush completes.
module cpu_trap_unit #(
    parameter int SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    cpu_trap_if.slave bus
);
    import cpu_trap_pkg::*;

    logic ext_s, soft_s, timer_s;

    cpu_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext   (.clk(clk), .rst(rst), .d(bus.irq_ext),   .q(ext_s));
    cpu_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_soft  (.clk(clk), .rst(rst), .d(bus.irq_soft),  .q(soft_s));
    cpu_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (.clk(clk), .rst(rst), .d(bus.irq_timer), .q(timer_s));

    logic [31:0] pending_vec;
    logic        take_ext, take_soft, take_timer;
    logic        unused_sie_bits;

    always_comb begin
        pending_vec          = '0;
        pending_vec[IRQ_SEI] = ext_s;
        pending_vec[IRQ_STI] = timer_s;
        pending_vec[IRQ_SSI] = soft_s;
    end

    assign take_ext   = ext_s   & bus.sie_mask[IRQ_SEI] & bus.status_sie;
    assign take_soft  = soft_s  & bus.sie_mask[IRQ_SSI] & bus.status_sie;
    assign take_timer = timer_s & bus.sie_mask[IRQ_STI] & bus.status_sie;
    assign unused_sie_bits = ^{bus.sie_mask[31:10], bus.sie_mask[8:6], bus.sie_mask[4:2], bus.sie_mask[0]};

    logic [1:0]  state_q;
    trap_rec_t   rec_q, rec_d;
    logic        take_trap, take_sret;
    logic        sret_redir_q;
    logic [31:0] sret_pc_q;

    // Boundary decision; only evaluated in IDLE so nothing nests while stalled.
    always_comb begin
        take_trap = 1'b0;
        take_sret = 1'b0;
        rec_d     = '0;
        if (state_q == ST_IDLE && bus.inst_done) begin
            if (bus.exc_valid) begin
                take_trap   = 1'b1;
                rec_d.cause = {27'b0, bus.exc_code};
                rec_d.pc    = bus.inst_pc;
                rec_d.value = bus.exc_value;
            end else if (bus.sret) begin
                take_sret = 1'b1;
            end else if (take_ext | take_soft | take_timer) begin
                take_trap = 1'b1;
                rec_d.pc  = bus.next_pc;
                if (take_ext)
                    rec_d.cause = irq_cause(IRQ_SEI);
                else if (take_soft)
                    rec_d.cause = irq_cause(IRQ_SSI);
                else
                    rec_d.cause = irq_cause(IRQ_STI);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rec_q        <= '0;
            sret_redir_q <= 1'b0;
            sret_pc_q    <= '0;
        end else begin
            sret_redir_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_trap) begin
                        rec_q   <= rec_d;
                        state_q <= ST_TRAP;
                    end else if (take_sret) begin
                        sret_redir_q <= 1'b1;
                        sret_pc_q    <= bus.continue_addr;
                        state_q      <= ST_FLUSH;
                    end
                end
                ST_TRAP:  state_q <= ST_FLUSH;
                ST_FLUSH: if (bus.flush_done) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    logic in_trap;
    assign in_trap = (state_q == ST_TRAP);

    assign bus.interrupt       = in_trap;
    assign bus.interrupt_cause = rec_q.cause;
    assign bus.interrupt_pc    = rec_q.pc;
    assign bus.interrupt_value = rec_q.value;
    assign bus.redirect        = in_trap | sret_redir_q;
    assign bus.stall           = (state_q != ST_IDLE);
    assign bus.pending         = pending_vec;
    assign bus.fsm_state       = state_q;

    always_comb begin
        bus.redirect_pc = 32'd0;
        if (in_trap)
            bus.redirect_pc = trap_target(bus.handler_addr, rec_q.cause);
        else if (sret_redir_q)
            bus.redirect_pc = sret_pc_q;
    end

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Bench for cpu_trap_unit: directed vector table, hand-written reset/stall sequences and a
// randomized phase scored against a transaction-level model through an expected queue.
module tb_cpu_trap_unit;
    import cpu_trap_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic mon_en;
    logic [128:0] exp_q[$];

    cpu_trap_if bus ();

    cpu_trap_unit #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_done     = 1'b0;
        bus.inst_pc       = '0;
        bus.next_pc       = '0;
        bus.exc_valid     = 1'b0;
        bus.exc_code      = '0;
        bus.exc_value     = '0;
        bus.sret          = 1'b0;
        bus.irq_ext       = 1'b0;
        bus.irq_soft      = 1'b0;
        bus.irq_timer     = 1'b0;
        bus.status_sie    = 1'b0;
        bus.sie_mask      = '0;
        bus.handler_addr  = '0;
        bus.continue_addr = '0;
        bus.flush_done    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {hit, is_trap, cause, pc, value, redirect_pc} for one instruction boundary.
    function automatic logic [129:0] ref_model(
        input logic exc, input logic [4:0] code, input logic [31:0] ipc, input logic [31:0] npc,
        input logic [31:0] val, input logic sr, input logic [2:0] lines, input logic sie,
        input logic [31:0] mask, input logic [31:0] stvec, input logic [31:0] sepc);
        logic [31:0] base, rpc;
        int order[3];
        logic line_on;
        order[0] = 9; order[1] = 1; order[2] = 5;
        base = (stvec / 4) * 4;
        if (exc)
            return {1'b1, 1'b1, 32'(code), ipc, val, base};
        if (sr)
            return {1'b1, 1'b0, 96'd0, sepc};
        for (int k = 0; k < 3; k++) begin
            int c;
            c = order[k];
            line_on = (c == 9) ? lines[2] : (c == 1) ? lines[1] : lines[0];
            if (line_on && mask[c] && sie) begin
                rpc = base + ((stvec % 4 == 1) ? 32'(4 * c) : 32'd0);
                return {1'b1, 1'b1, 32'h8000_0000 + 32'(c), npc, 32'd0, rpc};
            end
        end
        return '0;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && (bus.interrupt || bus.redirect)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: interrupt=%0b redirect=%0b rpc=0x%08h, expected no strobe",
                         bus.interrupt, bus.redirect, bus.redirect_pc);
            end else begin
                logic [128:0] e;
                e = exp_q.pop_front();
                if (bus.interrupt !== e[128] || bus.redirect !== 1'b1 || bus.redirect_pc !== e[31:0] ||
                    (e[128] && ({bus.interrupt_cause, bus.interrupt_pc, bus.interrupt_value} !== e[127:32]))) begin
                    errors++;
                    $display("FAIL sb_strobe: got int=%0b redir=%0b cause=%08h pc=%08h val=%08h rpc=%08h expected int=%0b cause=%08h pc=%08h val=%08h rpc=%08h",
                             bus.interrupt, bus.redirect, bus.interrupt_cause, bus.interrupt_pc,
                             bus.interrupt_value, bus.redirect_pc, e[128], e[127:96], e[95:64],
                             e[63:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic [31:0] inst_pc, next_pc, exc_value;
        logic        sret;
        logic [2:0]  irq;         // {ext, soft, timer}
        logic        sie;
        logic [31:0] sie_mask, stvec, sepc;
        logic        exp_int, exp_redir;
        logic [31:0] exp_cause, exp_pc, exp_value, exp_rpc;
    } vec_t;

    function automatic vec_t mk(
        input logic ev, input logic [4:0] ec, input logic [31:0] ipc, input logic [31:0] npc,
        input logic [31:0] ev_val, input logic sr, input logic [2:0] irq, input logic sie,
        input logic [31:0] mask, input logic [31:0] stvec, input logic [31:0] sepc,
        input logic ei, input logic er, input logic [31:0] ecause, input logic [31:0] epc,
        input logic [31:0] eval, input logic [31:0] erpc);
        vec_t v;
        v.exc_valid = ev;   v.exc_code = ec;   v.inst_pc = ipc;   v.next_pc = npc;
        v.exc_value = ev_val; v.sret = sr;     v.irq = irq;       v.sie = sie;
        v.sie_mask = mask;  v.stvec = stvec;   v.sepc = sepc;
        v.exp_int = ei;     v.exp_redir = er;  v.exp_cause = ecause;
        v.exp_pc = epc;     v.exp_value = eval; v.exp_rpc = erpc;
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        do_reset();
        bus.irq_ext       = v.irq[2];
        bus.irq_soft      = v.irq[1];
        bus.irq_timer     = v.irq[0];
        bus.status_sie    = v.sie;
        bus.sie_mask      = v.sie_mask;
        bus.handler_addr  = v.stvec;
        bus.continue_addr = v.sepc;
        bus.inst_pc       = v.inst_pc;
        bus.next_pc       = v.next_pc;
        bus.exc_code      = v.exc_code;
        bus.exc_value     = v.exc_value;
        repeat (3) step();
        bus.inst_done = 1'b1;
        bus.exc_valid = v.exc_valid;
        bus.sret      = v.sret;
        step();
        bus.inst_done = 1'b0;
        bus.exc_valid = 1'b0;
        bus.sret      = 1'b0;
        chk($sformatf("v%0d_interrupt", i), {31'b0, bus.interrupt}, {31'b0, v.exp_int});
        chk($sformatf("v%0d_redirect", i), {31'b0, bus.redirect}, {31'b0, v.exp_redir});
        chk($sformatf("v%0d_stall", i), {31'b0, bus.stall}, {31'b0, v.exp_int | v.exp_redir});
        if (v.exp_int) begin
            chk($sformatf("v%0d_cause", i), bus.interrupt_cause, v.exp_cause);
            chk($sformatf("v%0d_pc", i), bus.interrupt_pc, v.exp_pc);
            chk($sformatf("v%0d_value", i), bus.interrupt_value, v.exp_value);
        end
        if (v.exp_redir)
            chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, v.exp_rpc);
        step();
        chk($sformatf("v%0d_strobe_end", i), {30'b0, bus.interrupt, bus.redirect}, 32'd0);
    endtask

    vec_t vecs[15];

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        idle_inputs();

        vecs[0]  = mk(1, 2, 32'h100, 32'h104, 32'hDEAD, 0, 3'b000, 0, 32'h0,   32'h8000, 32'h0,  1, 1, 32'h2,        32'h100, 32'hDEAD, 32'h8000);
        vecs[1]  = mk(0, 0, 32'h200, 32'h204, 32'h55,   0, 3'b001, 1, 32'h20,  32'h8001, 32'h0,  1, 1, 32'h80000005, 32'h204, 32'h0,    32'h8014);
        vecs[2]  = mk(0, 0, 32'h200, 32'h204, 32'h55,   0, 3'b001, 0, 32'h20,  32'h8001, 32'h0,  0, 0, 32'h0,        32'h0,   32'h0,    32'h0);
        vecs[3]  = mk(1, 8, 32'h400, 32'h404, 32'h77,   0, 3'b111, 1, 32'h222, 32'h8001, 32'h0,  1, 1, 32'h8,        32'h400, 32'h77,   32'h8000);
        vecs[4]  = mk(0, 0, 32'h400, 32'h404, 32'h77,   0, 3'b111, 1, 32'h222, 32'h8001, 32'h0,  1, 1, 32'h80000009, 32'h404, 32'h0,    32'h8024);
        vecs[5]  = mk(0, 0, 32'h500, 32'h508, 32'h0,    0, 3'b011, 1, 32'h222, 32'h8001, 32'h0,  1, 1, 32'h80000001, 32'h508, 32'h0,    32'h8004);
        vecs[6]  = mk(0, 0, 32'h600, 32'h604, 32'h0,    1, 3'b000, 0, 32'h0,   32'h8000, 32'h300, 0, 1, 32'h0,       32'h0,   32'h0,    32'h300);
        vecs[7]  = mk(1, 3, 32'h700, 32'h704, 32'h1234, 1, 3'b000, 0, 32'h0,   32'h9000, 32'h300, 1, 1, 32'h3,       32'h700, 32'h1234, 32'h9000);
        vecs[8]  = mk(0, 0, 32'h800, 32'h804, 32'h0,    0, 3'b101, 1, 32'h20,  32'h8001, 32'h0,  1, 1, 32'h80000005, 32'h804, 32'h0,    32'h8014);
        vecs[9]  = mk(0, 0, 32'h900, 32'h904, 32'h0,    0, 3'b001, 1, 32'h20,  32'h8003, 32'h0,  1, 1, 32'h80000005, 32'h904, 32'h0,    32'h8000);
        vecs[10] = mk(0, 0, 32'hA00, 32'hA04, 32'h0,    0, 3'b100, 1, 32'h200, 32'hFFFFFFF1, 32'h0, 1, 1, 32'h80000009, 32'hA04, 32'h0,  32'h14);
        vecs[11] = mk(0, 0, 32'hB00, 32'hB04, 32'h0,    1, 3'b111, 1, 32'h222, 32'h8001, 32'h440, 0, 1, 32'h0,       32'h0,   32'h0,    32'h440);
        vecs[12] = mk(1, 0, 32'hC00, 32'hC04, 32'hC01,  0, 3'b000, 1, 32'h222, 32'h8001, 32'h0,  1, 1, 32'h0,        32'hC00, 32'hC01,  32'h8000);
        vecs[13] = mk(0, 0, 32'hD00, 32'hD04, 32'h0,    0, 3'b111, 1, 32'h0,   32'h8001, 32'h0,  0, 0, 32'h0,        32'h0,   32'h0,    32'h0);
        vecs[14] = mk(0, 0, 32'hE00, 32'hE04, 32'h0,    0, 3'b010, 1, 32'h2,   32'h8002, 32'h0,  1, 1, 32'h80000001, 32'hE04, 32'h0,    32'h8000);

        // reset state
        do_reset();
        chk("rst_interrupt", {31'b0, bus.interrupt}, 32'd0);
        chk("rst_redirect", {31'b0, bus.redirect}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_cause", bus.interrupt_cause, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        chk("rst_state", {30'b0, bus.fsm_state}, {30'b0, ST_IDLE});

        // synchroniser latency and no action without a boundary
        bus.irq_ext    = 1'b1;
        bus.irq_soft   = 1'b1;
        bus.irq_timer  = 1'b1;
        bus.status_sie = 1'b1;
        bus.sie_mask   = 32'hFFFF_FFFF;
        step();
        chk("pending_lat1", bus.pending, 32'd0);
        step();
        chk("pending_lat2", bus.pending, 32'h222);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("no_boundary_%0d", k), {30'b0, bus.stall, bus.redirect | bus.interrupt}, 32'd0);
        end

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // reset mid-FLUSH aborts cleanly
        do_reset();
        bus.exc_code     = 5'd2;
        bus.handler_addr = 32'h8000;
        bus.inst_done    = 1'b1;
        bus.exc_valid    = 1'b1;
        step();
        bus.inst_done = 1'b0;
        bus.exc_valid = 1'b0;
        step();
        chk("mid_flush_state", {30'b0, bus.fsm_state}, {30'b0, ST_FLUSH});
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'b0, bus.stall}, 32'd0);
        chk("midrst_strobes", {30'b0, bus.interrupt, bus.redirect}, 32'd0);
        chk("midrst_state", {30'b0, bus.fsm_state}, {30'b0, ST_IDLE});
        step();
        rst = 1'b0;
        step();
        chk("postrst_stall", {31'b0, bus.stall}, 32'd0);
        chk("postrst_interrupt", {31'b0, bus.interrupt}, 32'd0);

        // stall window: flush_done in the 5th FLUSH cycle, faults during the stall ignored
        begin
            int stall_cnt;
            int extra_int;
            do_reset();
            bus.exc_code     = 5'd8;
            bus.handler_addr = 32'h8000;
            bus.inst_done    = 1'b1;
            bus.exc_valid    = 1'b1;
            step();
            stall_cnt = 0;
            extra_int = 0;
            for (int k = 0; k < 20; k++) begin
                if (!bus.stall) break;
                stall_cnt++;
                if (k > 0 && bus.interrupt) extra_int++;
                bus.flush_done = (stall_cnt == 6);
                bus.inst_done  = 1'b1;
                bus.exc_valid  = k[0];
                step();
            end
            bus.flush_done = 1'b0;
            bus.inst_done  = 1'b0;
            bus.exc_valid  = 1'b0;
            chk("stall_cycles", stall_cnt, 32'd6);
            chk("stall_nested_int", extra_int, 32'd0);
            step();
            chk("stall_after", {30'b0, bus.stall, bus.interrupt}, 32'd0);
        end

        // randomized boundaries scored against the model
        do_reset();
        mon_en = 1'b1;
        for (int t = 0; t < 80; t++) begin
            logic [2:0]   lines;
            logic         boundary;
            logic [129:0] m;
            lines              = 3'($urandom_range(0, 7));
            bus.irq_ext        = lines[2];
            bus.irq_soft       = lines[1];
            bus.irq_timer      = lines[0];
            bus.status_sie     = ($urandom_range(0, 3) != 0);
            bus.sie_mask       = $urandom;
            bus.handler_addr   = $urandom;
            bus.continue_addr  = $urandom;
            bus.inst_pc        = $urandom;
            bus.next_pc        = $urandom;
            bus.exc_value      = $urandom;
            bus.exc_code       = 5'($urandom_range(0, 15));
            boundary           = ($urandom_range(0, 5) != 0);
            repeat (3) step();
            if (boundary) begin
                bus.exc_valid = ($urandom_range(0, 3) == 0);
                bus.sret      = ($urandom_range(0, 4) == 0);
                m = ref_model(bus.exc_valid, bus.exc_code, bus.inst_pc, bus.next_pc, bus.exc_value,
                              bus.sret, lines, bus.status_sie, bus.sie_mask, bus.handler_addr,
                              bus.continue_addr);
                if (m[129]) exp_q.push_back(m[128:0]);
                bus.inst_done = 1'b1;
                step();
                bus.inst_done = 1'b0;
                bus.exc_valid = 1'b0;
                bus.sret      = 1'b0;
            end
            for (int k = 0; k < 40; k++) begin
                if (!bus.stall) break;
                bus.flush_done = (k >= 20) || ($urandom_range(0, 3) == 0);
                bus.inst_done  = 1'($urandom_range(0, 1));
                bus.exc_valid  = 1'($urandom_range(0, 1));
                bus.sret       = 1'($urandom_range(0, 1));
                step();
            end
            bus.flush_done = 1'b0;
            bus.inst_done  = 1'b0;
            bus.exc_valid  = 1'b0;
            bus.sret       = 1'b0;
            chk($sformatf("rand%0d_flush_exit", t), {31'b0, bus.stall}, 32'd0);
        end
        step();
        mon_en = 1'b0;
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
